// File: rtl/alu_share_ctrl.sv
// Shared 64-bit execute ALU with a two-way round-robin arbiter.
// Holds one result at a time under a valid/ready response handshake.
module alu_share_ctrl #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [1:0]   req0_op,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_set_cc,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [1:0]   req1_op,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req1_set_cc,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_result,
    output logic         cc_zf,
    output logic         cc_sf,
    output logic         cc_of
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t       state;
    logic         ptr;
    logic [1:0]   op_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic         set_cc_q;
    logic         id_q;

    logic         gnt1;
    logic         take;
    logic [W-1:0] alu_res;
    logic         alu_of;

    // Round-robin grant: pointer only matters when both requesters are valid
    always_comb begin
        gnt1 = req1_valid && (!req0_valid || ptr);
        take = (state == IDLE) && (req0_valid || req1_valid);
    end

    assign req0_ready = take && !gnt1;
    assign req1_ready = take && gnt1;

    // ALU on the latched operands; carry-out is dropped, OF only for ADD/SUB
    always_comb begin
        alu_res = '0;
        alu_of  = 1'b0;
        unique case (op_q)
            2'd0: begin
                alu_res = a_q + b_q;
                alu_of  = (a_q[W-1] == b_q[W-1])
                       && (alu_res[W-1] != a_q[W-1]);
            end
            2'd1: begin
                alu_res = a_q - b_q;
                alu_of  = (a_q[W-1] != b_q[W-1])
                       && (alu_res[W-1] != a_q[W-1]);
            end
            2'd2: alu_res = a_q & b_q;
            2'd3: alu_res = a_q ^ b_q;
            default: alu_res = '0;
        endcase
    end

    // Sequencer: accept in IDLE, compute in EXEC, hold response in RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            op_q       <= 2'd0;
            a_q        <= '0;
            b_q        <= '0;
            set_cc_q   <= 1'b0;
            id_q       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            cc_zf      <= 1'b1;
            cc_sf      <= 1'b0;
            cc_of      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (take) begin
                        op_q     <= gnt1 ? req1_op : req0_op;
                        a_q      <= gnt1 ? req1_a : req0_a;
                        b_q      <= gnt1 ? req1_b : req0_b;
                        set_cc_q <= gnt1 ? req1_set_cc : req0_set_cc;
                        id_q     <= gnt1;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_res;
                    rsp_id     <= id_q;
                    rsp_valid  <= 1'b1;
                    if (set_cc_q) begin
                        cc_zf <= (alu_res == '0);
                        cc_sf <= alu_res[W-1];
                        cc_of <= alu_of;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ptr       <= ~id_q;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
